// File: rtl/mux_pkg.sv
// Constants shared by the 4:1 mux tree, its probador and the receive-side demux.
package mux_pkg;
    localparam int DATA_W    = 9;
    localparam int VALID_BIT = 8;
    localparam int LANES     = 4;
    localparam int LANE_W    = 2;

    localparam logic [DATA_W-1:0] INVALID_WORD = 9'h000;
endpackage

// File: rtl/lane_cnt.sv
// Mod-4 lane slot counter. A lane-0 strobe realigns it and reports when the
// strobe landed in the middle of a frame.
module lane_cnt
    import mux_pkg::*;
(
    input  logic              clk4f,
    input  logic              reset,
    input  logic              load0,
    output logic [LANE_W-1:0] lane,
    output logic              mid_frame
);

    logic [LANE_W-1:0] r_lane;
    logic [LANE_W-1:0] w_lane_nxt;

    // The strobed word occupies slot 0, so the following word lands in slot 1.
    always_comb begin
        w_lane_nxt = r_lane + LANE_W'(1);
        if (load0) begin
            w_lane_nxt = LANE_W'(1);
        end
    end

    always_ff @(posedge clk4f) begin
        if (reset) begin
            r_lane <= '0;
        end else begin
            r_lane <= w_lane_nxt;
        end
    end

    assign lane      = r_lane;
    assign mid_frame = load0 && (r_lane != '0);

endmodule

// File: rtl/demux_l2.sv
// Serial-to-parallel demux: rebuilds four lanes from the final mux stage's word
// stream and presents them as one registered frame every four cycles.
module demux_l2
    import mux_pkg::*;
#(
    parameter int DATA_W = mux_pkg::DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk4f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              lane0,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [DATA_W-1:0] data_out3,
    output logic              frame_valid,
    output logic              align_err,
    output logic [CNT_W-1:0]  frame_cnt
);

    logic [LANE_W-1:0] w_lane;
    logic              w_mid_frame;
    logic [DATA_W-1:0] w_word;

    logic [DATA_W-1:0] r_shadow0;
    logic [DATA_W-1:0] r_shadow1;
    logic [DATA_W-1:0] r_shadow2;
    logic [DATA_W-1:0] r_out0;
    logic [DATA_W-1:0] r_out1;
    logic [DATA_W-1:0] r_out2;
    logic [DATA_W-1:0] r_out3;
    logic              r_frame_valid;
    logic              r_align_err;
    logic [CNT_W-1:0]  r_frame_cnt;

    lane_cnt u_lane_cnt (
        .clk4f     (clk4f),
        .reset     (reset),
        .load0     (lane0),
        .lane      (w_lane),
        .mid_frame (w_mid_frame)
    );

    // Payloads of invalid slots must never reach the outputs.
    assign w_word = data_in[DATA_W-1] ? data_in : DATA_W'(INVALID_WORD);

    always_ff @(posedge clk4f) begin
        if (reset) begin
            r_shadow0     <= '0;
            r_shadow1     <= '0;
            r_shadow2     <= '0;
            r_out0        <= '0;
            r_out1        <= '0;
            r_out2        <= '0;
            r_out3        <= '0;
            r_frame_valid <= 1'b0;
            r_align_err   <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            r_align_err   <= w_mid_frame;
            if (lane0) begin
                // Realign: this word starts a new frame; a partial frame is dropped,
                // including one that would have completed on this very edge.
                r_shadow0 <= w_word;
                if (w_mid_frame) begin
                    r_shadow1 <= '0;
                    r_shadow2 <= '0;
                end
            end else begin
                case (w_lane)
                    2'd0: r_shadow0 <= w_word;
                    2'd1: r_shadow1 <= w_word;
                    2'd2: r_shadow2 <= w_word;
                    default: begin
                        r_out0        <= r_shadow0;
                        r_out1        <= r_shadow1;
                        r_out2        <= r_shadow2;
                        r_out3        <= w_word;
                        r_frame_valid <= 1'b1;
                        r_frame_cnt   <= r_frame_cnt + CNT_W'(1);
                    end
                endcase
            end
        end
    end

    assign data_out0   = r_out0;
    assign data_out1   = r_out1;
    assign data_out2   = r_out2;
    assign data_out3   = r_out3;
    assign frame_valid = r_frame_valid;
    assign align_err   = r_align_err;
    assign frame_cnt   = r_frame_cnt;

endmodule
